video_sync_gen: RTL and testbench

VIDEO_SYNC_GEN -- requirements
Module: video_sync_gen

---
 rtl/video_sync_gen.sv | 128 ++++++++++++
 tb/tb_video_sync_gen.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/video_sync_gen.sv
// video_sync_gen: raster timing generator with a FIFO-fed pixel path.
// Each line and each frame runs front porch, sync, back porch, then active.
// The pixel path starts reading the upstream FWFT FIFO once the FIFO
// reports ready and a frame boundary has been reached. After that it never
// stops until reset. Every video output is registered one cycle after the
// counter state that produces it.
// Optional build macro VIDEO_SYNC_GEN_TEST_PATTERN_EN replaces the FIFO
// pixels with 8 vertical colour bars and disables all FIFO reads.
module video_sync_gen #(
  parameter int HDISP  = 800,
  parameter int VDISP  = 480,
  parameter int HFP    = 40,
  parameter int HPULSE = 48,
  parameter int HBP    = 40,
  parameter int VFP    = 13,
  parameter int VPULSE = 3,
  parameter int VBP    = 29
) (
  input  logic        pixel_clk,
  input  logic        pixel_rst,
  input  logic        fifo_ready,
  input  logic        fifo_empty,
  input  logic [23:0] fifo_rdata,
  output logic        fifo_read,
  output logic        video_HS,
  output logic        video_VS,
  output logic        video_BLANK,
  output logic [23:0] video_RGB,
  output logic        underflow
);

  localparam int HTOT = HFP + HPULSE + HBP + HDISP;
  localparam int VTOT = VFP + VPULSE + VBP + VDISP;
  localparam int HACT = HFP + HPULSE + HBP;
  localparam int VACT = VFP + VPULSE + VBP;
  localparam int HW   = $clog2(HTOT);
  localparam int VW   = $clog2(VTOT);

  typedef enum logic [1:0] {WAIT_READY, WAIT_FRAME, RUN} state_t;

  state_t        state_q, state_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [VW-1:0] vcnt_q, vcnt_d;
  logic          hs_q, hs_d;
  logic          vs_q, vs_d;
  logic          blank_q, blank_d;
  logic [23:0]   rgb_q, rgb_d;
  logic          uf_q, uf_d;
  logic          active;
  logic          h_end;
  logic          v_end;

`ifdef VIDEO_SYNC_GEN_TEST_PATTERN_EN
  logic [31:0]   bar_k;
`endif

  // Raster counters: the line counter advances only when the pixel counter wraps.
  always_comb begin
    h_end  = (hcnt_q == HW'(HTOT - 1));
    v_end  = (vcnt_q == VW'(VTOT - 1));
    hcnt_d = h_end ? '0 : hcnt_q + 1'b1;
    vcnt_d = vcnt_q;
    if (h_end) begin
      vcnt_d = v_end ? '0 : vcnt_q + 1'b1;
    end
    active = (hcnt_q >= HW'(HACT)) && (vcnt_q >= VW'(VACT));
  end

  // Start-up sequencing: wait for FIFO data, then align to a frame start.
  // A later drop of fifo_ready is ignored because RUN never exits.
  always_comb begin
    state_d = state_q;
    case (state_q)
      WAIT_READY: if (fifo_ready) state_d = WAIT_FRAME;
      WAIT_FRAME: if (hcnt_q == '0 && vcnt_q == '0) state_d = RUN;
      RUN:        state_d = RUN;
      default:    state_d = WAIT_READY;
    endcase
  end

  // Next values of the registered video outputs, plus the FIFO pop strobe.
  always_comb begin
    hs_d    = !((hcnt_q >= HW'(HFP)) && (hcnt_q < HW'(HFP + HPULSE)));
    vs_d    = !((vcnt_q >= VW'(VFP)) && (vcnt_q < VW'(VFP + VPULSE)));
    blank_d = active;
`ifdef VIDEO_SYNC_GEN_TEST_PATTERN_EN
    bar_k     = (32'(hcnt_q) - 32'(HACT)) * 32'd8 / 32'(HDISP);
    fifo_read = 1'b0;
    rgb_d     = active ? {{8{bar_k[2]}}, {8{bar_k[1]}}, {8{bar_k[0]}}} : 24'h0;
    uf_d      = 1'b0;
`else
    // A pixel that finds the FIFO empty is dropped (black), not delayed.
    fifo_read = (state_q == RUN) && active && !fifo_empty;
    rgb_d     = fifo_read ? fifo_rdata : 24'h0;
    uf_d      = uf_q | ((state_q == RUN) && active && fifo_empty);
`endif
  end

  // All state, including the output registers, is cleared asynchronously.
  always_ff @(posedge pixel_clk or posedge pixel_rst) begin
    if (pixel_rst) begin
      state_q <= WAIT_READY;
      hcnt_q  <= '0;
      vcnt_q  <= '0;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      blank_q <= 1'b0;
      rgb_q   <= 24'h0;
      uf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
      vcnt_q  <= vcnt_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      blank_q <= blank_d;
      rgb_q   <= rgb_d;
      uf_q    <= uf_d;
    end
  end

  assign video_HS    = hs_q;
  assign video_VS    = vs_q;
  assign video_BLANK = blank_q;
  assign video_RGB   = rgb_q;
  assign underflow   = uf_q;

endmodule

// File: tb/tb_video_sync_gen.sv
// tb_video_sync_gen: randomized bench for video_sync_gen at 160x90.
// A reference model derives the raster position from an elapsed-cycle count
// with plain division and modulo. It treats the pixel path as running from
// the first frame that starts after fifo_ready was first seen, and it models
// the FIFO as an incrementing word stream from a random starting value.
module tb_video_sync_gen;

  localparam int HDISP  = 160;
  localparam int VDISP  = 90;
  localparam int HFP    = 40;
  localparam int HPULSE = 48;
  localparam int HBP    = 40;
  localparam int VFP    = 13;
  localparam int VPULSE = 3;
  localparam int VBP    = 29;
  localparam int HTOT   = HFP + HPULSE + HBP + HDISP;
  localparam int VTOT   = VFP + VPULSE + VBP + VDISP;
  localparam int FTOT   = HTOT * VTOT;
  localparam int HACT   = HFP + HPULSE + HBP;
  localparam int VACT   = VFP + VPULSE + VBP;

  logic        pixel_clk  = 1'b0;
  logic        pixel_rst  = 1'b1;
  logic        fifo_ready = 1'b0;
  logic        fifo_empty = 1'b1;
  logic [23:0] fifo_rdata = 24'h0;
  logic        fifo_read;
  logic        video_HS;
  logic        video_VS;
  logic        video_BLANK;
  logic [23:0] video_RGB;
  logic        underflow;

  video_sync_gen #(
    .HDISP(HDISP), .VDISP(VDISP), .HFP(HFP), .HPULSE(HPULSE), .HBP(HBP),
    .VFP(VFP), .VPULSE(VPULSE), .VBP(VBP)
  ) dut (
    .pixel_clk  (pixel_clk),
    .pixel_rst  (pixel_rst),
    .fifo_ready (fifo_ready),
    .fifo_empty (fifo_empty),
    .fifo_rdata (fifo_rdata),
    .fifo_read  (fifo_read),
    .video_HS   (video_HS),
    .video_VS   (video_VS),
    .video_BLANK(video_BLANK),
    .video_RGB  (video_RGB),
    .underflow  (underflow)
  );

  always #5 pixel_clk = ~pixel_clk;

  int          n_vec = 0;
  int          n_err = 0;
  int          t;
  int          r_rise;
  int          epoch;
  int          burst_col;
  int          rd_cnt [3];
  logic [23:0] pix;
  logic        exp_hs;
  logic        exp_vs;
  logic        exp_blank;
  logic        exp_uf;
  logic [23:0] exp_rgb;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s epoch=%0d t=%0d got=%h expected=%h", tag, epoch, t, got, exp);
    end
  endtask

  task automatic expect_reset_values();
    exp_hs    = 1'b1;
    exp_vs    = 1'b1;
    exp_blank = 1'b0;
    exp_rgb   = 24'h0;
    exp_uf    = 1'b0;
  endtask

  // One pixel period: check registered outputs, drive inputs, check the pop strobe, advance the model.
  task automatic do_cycle();
    int h, v, fr, bar;
    bit act, run, emp, rd_exp;
    check_eq("video_HS", 32'(video_HS), 32'(exp_hs));
    check_eq("video_VS", 32'(video_VS), 32'(exp_vs));
    check_eq("video_BLANK", 32'(video_BLANK), 32'(exp_blank));
    check_eq("video_RGB", 32'(video_RGB), 32'(exp_rgb));
    check_eq("underflow", 32'(underflow), 32'(exp_uf));

    h   = t % HTOT;
    v   = (t / HTOT) % VTOT;
    fr  = t / FTOT;
    act = (h >= HACT) && (v >= VACT);

    if (epoch == 0)
      fifo_ready = (t < 100) ? 1'b0 : (t == 100) ? 1'b1 : 1'($urandom_range(0, 3) != 0);
    else
      fifo_ready = 1'b1;
    if (fifo_ready && r_rise < 0) r_rise = t;
    run = (r_rise >= 0) && (fr >= r_rise / FTOT + 1);

    if (!run) emp = 1'($urandom_range(0, 1));
    else      emp = (fr == 2) && (v == VACT) && (h >= burst_col) && (h < burst_col + 5);
    fifo_empty = emp;
    fifo_rdata = emp ? 24'($urandom) : pix;
    #1;

`ifdef VIDEO_SYNC_GEN_TEST_PATTERN_EN
    rd_exp  = 1'b0;
    bar     = (h - HACT) * 8 / HDISP;
    exp_rgb = act ? {{8{bar[2]}}, {8{bar[1]}}, {8{bar[0]}}} : 24'h0;
`else
    bar     = 0;
    rd_exp  = run && act && !emp;
    exp_rgb = rd_exp ? pix : 24'h0;
    if (run && act && emp) exp_uf = 1'b1;
    if (rd_exp) pix = pix + 24'd1;
`endif
    check_eq("fifo_read", 32'(fifo_read), 32'(rd_exp));
    if (epoch == 0 && fr < 3 && fifo_read) rd_cnt[fr]++;

    exp_hs    = !((h >= HFP) && (h < HFP + HPULSE));
    exp_vs    = !((v >= VFP) && (v < VFP + VPULSE));
    exp_blank = act;
    t++;
    @(negedge pixel_clk);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) rd_cnt[i] = 0;
    pix       = 24'($urandom);
    burst_col = $urandom_range(HACT, HTOT - 5);
    epoch     = 0;
    t         = 0;
    r_rise    = -1;
    expect_reset_values();

    repeat (3) @(negedge pixel_clk);
    #1;
    check_eq("rst_HS", 32'(video_HS), 32'd1);
    check_eq("rst_VS", 32'(video_VS), 32'd1);
    check_eq("rst_BLANK", 32'(video_BLANK), 32'd0);
    check_eq("rst_RGB", 32'(video_RGB), 32'd0);
    check_eq("rst_underflow", 32'(underflow), 32'd0);
    check_eq("rst_fifo_read", 32'(fifo_read), 32'd0);
    @(negedge pixel_clk);
    pixel_rst = 1'b0;

    while (t < 2 * FTOT) do_cycle();
    check_eq("reads_frame1", 32'(rd_cnt[0]), 32'd0);
    check_eq("reads_frame2", 32'(rd_cnt[1]), 32'(HDISP * VDISP));

    while (t < 2 * FTOT + 60 * HTOT + 100) do_cycle();
`ifndef VIDEO_SYNC_GEN_TEST_PATTERN_EN
    check_eq("underflow_sticky", 32'(underflow), 32'd1);
`endif

    // Mid-frame reset must clear outputs without waiting for a clock edge.
    pixel_rst = 1'b1;
    #1;
    check_eq("midrst_HS", 32'(video_HS), 32'd1);
    check_eq("midrst_VS", 32'(video_VS), 32'd1);
    check_eq("midrst_BLANK", 32'(video_BLANK), 32'd0);
    check_eq("midrst_RGB", 32'(video_RGB), 32'd0);
    check_eq("midrst_underflow", 32'(underflow), 32'd0);
    check_eq("midrst_fifo_read", 32'(fifo_read), 32'd0);
    repeat (2) @(negedge pixel_clk);
    pixel_rst = 1'b0;
    epoch     = 1;
    t         = 0;
    r_rise    = -1;
    expect_reset_values();
    repeat (400) do_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
